// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: turns decoded field bundles into machine words
// and streams them into instruction memory through a registered write port.
module rv_instr_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_alu,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic [7:0]        err_count,
    output logic              busy,
    output logic              full
);

    typedef enum logic [1:0] {IDLE, RUN, FULL, DONE} state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t      state;
    logic        legal;
    logic        hs;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc;

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign full     = (state == FULL);
    assign hs       = in_valid && in_ready;

    always_comb begin
        legal = 1'b1;
        f3    = 3'b000;
        f7    = 7'b0000000;
        enc   = '0;
        case (in_kind)
            3'd0: begin
                case (in_alu)
                    3'b000: f3 = 3'b000;
                    3'b001: begin
                        f3 = 3'b000;
                        f7 = 7'b0100000;
                    end
                    3'b010: f3 = 3'b111;
                    3'b011: f3 = 3'b110;
                    3'b101: f3 = 3'b010;
                    default: legal = 1'b0;
                endcase
                enc = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            end
            3'd1: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            3'd2: enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            3'd3: enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                         in_imm[4:0], 7'b0100011};
            3'd4: begin
                legal = ~in_imm[0];
                enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                         in_imm[4:1], in_imm[11], 7'b1100011};
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
            err        <= 1'b0;
            err_count  <= '0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if (start) begin
                // a new session takes priority over anything else this edge
                state      <= RUN;
                word_count <= '0;
                err_count  <= '0;
            end else if (state == RUN) begin
                if (hs) begin
                    if (legal) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= word_count[ADDR_W-1:0];
                        mem_wdata  <= enc;
                        word_count <= word_count + 1'b1;
                        if (word_count == LAST)
                            state <= FULL;
                    end else begin
                        err <= 1'b1;
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                end
                if (finish)
                    state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed cases with literal words plus a
// randomized stream checked every cycle against a behavioural model.
module tb_rv_instr_encoder;

    localparam int AW = 3;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start, finish, in_valid, in_ready;
    logic [2:0]    in_kind, in_alu;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [12:0]   in_imm;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;
    logic          err;
    logic [7:0]    err_count;
    logic          busy, full;

    int checks = 0;
    int errors = 0;

    rv_instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_alu(in_alu), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .err(err),
        .err_count(err_count), .busy(busy), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit model_ok(int k, int a, int imm);
        if (k == 0) return (a == 0 || a == 1 || a == 2 || a == 3 || a == 5);
        if (k >= 1 && k <= 3) return 1'b1;
        if (k == 4) return (imm % 2) == 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_enc(int k, int a, int rd, int rs1,
                                              int rs2, int imm);
        int f3tab[8] = '{0, 0, 7, 6, 0, 2, 0, 0};
        logic [31:0] w;
        w = 0;
        case (k)
            0: w = 32'h33 | (rd << 7) | (f3tab[a] << 12) | (rs1 << 15)
                   | (rs2 << 20) | ((a == 1 ? 32 : 0) << 25);
            1: w = 32'h13 | (rd << 7) | (rs1 << 15) | ((imm & 'hFFF) << 20);
            2: w = 32'h03 | (rd << 7) | (2 << 12) | (rs1 << 15)
                   | ((imm & 'hFFF) << 20);
            3: w = 32'h23 | ((imm & 'h1F) << 7) | (2 << 12) | (rs1 << 15)
                   | (rs2 << 20) | (((imm >> 5) & 'h7F) << 25);
            4: w = 32'h63 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 'hF) << 8)
                   | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 'h3F) << 25)
                   | (((imm >> 12) & 1) << 31);
            default: w = 0;
        endcase
        return w;
    endfunction

    // model: 0 idle, 1 run, 2 full, 3 done
    int          m_st, m_cnt, m_errc, e_addr;
    bit          e_we, e_err;
    logic [31:0] e_wd;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st <= 0; m_cnt <= 0; m_errc <= 0; e_addr <= 0;
            e_we <= 0; e_err <= 0; e_wd <= 0;
        end else begin
            e_we  <= 0;
            e_err <= 0;
            if (start) begin
                m_st <= 1; m_cnt <= 0; m_errc <= 0;
            end else if (m_st == 1) begin
                if (in_valid) begin
                    if (model_ok(in_kind, in_alu, in_imm)) begin
                        e_we   <= 1;
                        e_addr <= m_cnt;
                        e_wd   <= model_enc(in_kind, in_alu, in_rd, in_rs1,
                                            in_rs2, in_imm);
                        m_cnt  <= m_cnt + 1;
                        if (m_cnt + 1 == DP) m_st <= 2;
                    end else begin
                        e_err <= 1;
                        if (m_errc < 255) m_errc <= m_errc + 1;
                    end
                end
                if (finish) m_st <= 3;
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("word_count", word_count, m_cnt);
        chk("err", err, e_err);
        chk("err_count", err_count, m_errc);
        chk("in_ready", in_ready, m_st == 1);
        chk("busy", busy, m_st == 1);
        chk("full", full, m_st == 2);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; start = 0; finish = 0;
    endtask

    task automatic setb(int k, int a, int rd, int rs1, int rs2, int imm);
        in_valid = 1; in_kind = 3'(k); in_alu = 3'(a);
        in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = 13'(imm);
    endtask

    task automatic do_start();
        idle(); start = 1; cyc(); start = 0;
    endtask

    int nw;

    initial begin
        idle();
        setb(0, 0, 0, 0, 0, 0);
        in_valid = 0;
        chk("pin_addi", model_enc(1, 0, 1, 0, 0, 5), 32'h00500093);
        chk("pin_sub", model_enc(0, 1, 3, 1, 2, 0), 32'h402081B3);
        chk("pin_sw", model_enc(3, 0, 0, 1, 2, 4), 32'h0020A223);
        chk("pin_beq", model_enc(4, 0, 0, 1, 2, 13'h1FFC), 32'hFE208EE3);
        cyc(); cyc();
        reset = 0;
        cyc();
        chk("rst_we", mem_we, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_ready", in_ready, 0);

        do_start();
        setb(1, 0, 1, 0, 0, 5); cyc(); idle();
        chk("addi_we", mem_we, 1);
        chk("addi_addr", mem_addr, 0);
        chk("addi_word", mem_wdata, 32'h00500093);
        chk("addi_wc", word_count, 1);

        do_start();
        setb(0, 0, 3, 1, 2, 0); cyc();
        chk("add_addr", mem_addr, 0);
        chk("add_word", mem_wdata, 32'h002081B3);
        setb(0, 1, 3, 1, 2, 0); cyc(); idle();
        chk("sub_we", mem_we, 1);
        chk("sub_addr", mem_addr, 1);
        chk("sub_word", mem_wdata, 32'h402081B3);

        do_start();
        setb(2, 0, 2, 0, 0, 8); cyc();
        chk("lw_word", mem_wdata, 32'h00802103);
        setb(3, 0, 0, 1, 2, 4); cyc();
        chk("sw_word", mem_wdata, 32'h0020A223);
        setb(4, 0, 0, 1, 2, -4); cyc(); idle();
        chk("beq_addr", mem_addr, 2);
        chk("beq_word", mem_wdata, 32'hFE208EE3);

        do_start();
        setb(6, 0, 1, 1, 1, 0); cyc();
        chk("ill_kind_err", err, 1);
        setb(0, 4, 1, 1, 1, 0); cyc();
        chk("ill_alu_we", mem_we, 0);
        setb(4, 0, 1, 2, 3, 3); cyc();
        chk("ill_beq_err", err, 1);
        chk("ill_count", err_count, 3);
        setb(1, 0, 1, 0, 0, 5); cyc(); idle();
        chk("after_ill_addr", mem_addr, 0);
        chk("after_ill_we", mem_we, 1);

        do_start();
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            setb(1, 0, i, 0, 0, i); cyc();
            if (mem_we) nw++;
        end
        idle();
        chk("depth_writes", nw, DP);
        chk("depth_full", full, 1);
        chk("depth_ready", in_ready, 0);
        chk("depth_wc", word_count, DP);
        do_start();
        setb(1, 0, 7, 0, 0, 1); cyc(); idle();
        chk("restart_addr", mem_addr, 0);
        chk("restart_we", mem_we, 1);

        do_start();
        setb(1, 0, 4, 4, 0, 9); finish = 1; cyc(); idle();
        chk("fin_we", mem_we, 1);
        chk("fin_ready", in_ready, 0);
        chk("fin_busy", busy, 0);

        do_start();
        setb(1, 0, 5, 5, 0, 3); cyc(); idle();
        #2 reset = 1;
        #1;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_word", mem_wdata, 0);
        chk("rstmid_wc", word_count, 0);
        chk("rstmid_busy", busy, 0);
        cyc(); cyc();
        reset = 0;
        cyc();
        chk("rstpost_we", mem_we, 0);

        for (int i = 0; i < 800; i++) begin
            idle();
            if ($urandom_range(99) < 3) begin
                start = 1;
            end else begin
                in_valid = $urandom_range(99) < 75;
                in_kind  = ($urandom_range(9) < 8) ? 3'($urandom_range(4))
                                                   : 3'($urandom_range(7, 5));
                in_alu   = 3'($urandom_range(7));
                in_rd    = 5'($urandom);
                in_rs1   = 5'($urandom);
                in_rs2   = 5'($urandom);
                in_imm   = 13'($urandom);
                if ($urandom_range(99) < 4 && m_cnt != DP - 1) finish = 1;
            end
            cyc();
        end
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
